// File: rtl/bsw_tb_cigar_packer.sv
// ---------------------------------------------------------------------------
// bsw_tb_cigar_packer
//
// Receive end of the BSW_Array traceback stream. Run-length encodes the
// 2-bit direction stream into CIGAR records {op, len, last}, buffers them in
// a first-word fall-through FIFO and presents them on a valid/ready port.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   dir, dir_valid      traceback direction beat (0=M, 1=I, 2=D, 3=reserved)
//   aln_done            one-cycle pulse, alignment traceback complete
//   cigar_op/len/last   FIFO head record
//   cigar_valid/ready   output handshake (transfer on valid & ready)
//   num_tb_steps        valid dir beats in the last flushed alignment
//   overflow            sticky, record dropped because the FIFO was full
//   proto_err           sticky, dir=3 seen or beat arrived during a flush
//   clear_err           clears both sticky flags
//
// Optional build macro BSW_CIGAR_STATS_EN adds m_count/i_count/d_count:
// accepted M/I/D beats of the last flushed alignment.
// ---------------------------------------------------------------------------
module bsw_tb_cigar_packer #(
    parameter int unsigned LEN_W      = 9,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned STEP_W     = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        dir,
    input  logic              dir_valid,
    input  logic              aln_done,
    output logic [1:0]        cigar_op,
    output logic [LEN_W-1:0]  cigar_len,
    output logic              cigar_last,
    output logic              cigar_valid,
    input  logic              cigar_ready,
    output logic [STEP_W-1:0] num_tb_steps,
    output logic              overflow,
    output logic              proto_err,
    input  logic              clear_err
`ifdef BSW_CIGAR_STATS_EN
    ,
    output logic [STEP_W-1:0] m_count,
    output logic [STEP_W-1:0] i_count,
    output logic [STEP_W-1:0] d_count
`endif
);

    localparam int unsigned REC_W = 2 + LEN_W + 1;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);

    localparam logic [LEN_W-1:0]  LEN_MAX  = '1;
    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
    localparam logic [STEP_W-1:0] STEP_MAX = '1;

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } state_t;

    state_t state, state_next;

    logic              run_open, run_open_next;
    logic [1:0]        run_op, run_op_next;
    logic [LEN_W-1:0]  run_len, run_len_next;
    logic [STEP_W-1:0] steps, steps_next;
    logic [STEP_W-1:0] num_next;

    logic              wr_en;
    logic [REC_W-1:0]  wr_rec;
    logic              proto_evt;

    // ------------------------------------------------------------------
    // Run-length encoder / flush sequencing
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_RUN;
            run_open     <= 1'b0;
            run_op       <= 2'd0;
            run_len      <= '0;
            steps        <= '0;
            num_tb_steps <= '0;
        end else begin
            state        <= state_next;
            run_open     <= run_open_next;
            run_op       <= run_op_next;
            run_len      <= run_len_next;
            steps        <= steps_next;
            num_tb_steps <= num_next;
        end
    end

    always_comb begin
        state_next    = state;
        run_open_next = run_open;
        run_op_next   = run_op;
        run_len_next  = run_len;
        steps_next    = steps;
        num_next      = num_tb_steps;
        wr_en         = 1'b0;
        wr_rec        = '0;
        proto_evt     = 1'b0;

        case (state)
            ST_RUN: begin
                // A beat coinciding with aln_done is folded into the run
                // before the flush cycle emits it.
                if (dir_valid) begin
                    if (steps != STEP_MAX) begin
                        steps_next = steps + 1'b1;
                    end
                    if (dir == 2'd3) begin
                        proto_evt = 1'b1;
                    end else if (!run_open) begin
                        run_open_next = 1'b1;
                        run_op_next   = dir;
                        run_len_next  = LEN_ONE;
                    end else if (dir == run_op && run_len != LEN_MAX) begin
                        run_len_next = run_len + 1'b1;
                    end else begin
                        wr_en        = 1'b1;
                        wr_rec       = {run_op, run_len, 1'b0};
                        run_op_next  = dir;
                        run_len_next = LEN_ONE;
                    end
                end
                if (aln_done) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (dir_valid) begin
                    proto_evt = 1'b1;
                end
                wr_en = 1'b1;
                if (run_open) begin
                    wr_rec = {run_op, run_len, 1'b1};
                end else begin
                    wr_rec = {2'd0, {LEN_W{1'b0}}, 1'b1};
                end
                run_open_next = 1'b0;
                steps_next    = '0;
                num_next      = steps;
                state_next    = ST_RUN;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

`ifdef BSW_CIGAR_STATS_EN
    // ------------------------------------------------------------------
    // Per-op beat counters, latched at the flush like num_tb_steps
    // ------------------------------------------------------------------
    logic [STEP_W-1:0] m_cnt, i_cnt, d_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt   <= '0;
            i_cnt   <= '0;
            d_cnt   <= '0;
            m_count <= '0;
            i_count <= '0;
            d_count <= '0;
        end else if (state == ST_FLUSH) begin
            m_count <= m_cnt;
            i_count <= i_cnt;
            d_count <= d_cnt;
            m_cnt   <= '0;
            i_cnt   <= '0;
            d_cnt   <= '0;
        end else if (dir_valid) begin
            if (dir == 2'd0 && m_cnt != STEP_MAX) m_cnt <= m_cnt + 1'b1;
            if (dir == 2'd1 && i_cnt != STEP_MAX) i_cnt <= i_cnt + 1'b1;
            if (dir == 2'd2 && d_cnt != STEP_MAX) d_cnt <= d_cnt + 1'b1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Record FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    logic [REC_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             empty, full, rd_en, wr_ok, ovf_evt;
    logic [REC_W-1:0] head;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en   = !empty && cigar_ready;
    // A full FIFO still accepts a write when the head leaves the same cycle.
    assign wr_ok   = wr_en && (!full || rd_en);
    assign ovf_evt = wr_en && full && !rd_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr[AW-1:0]] <= wr_rec;
        end
    end

    assign head        = mem[rd_ptr[AW-1:0]];
    assign cigar_valid = !empty;
    // Storage is not reset, so the head is masked while nothing is queued.
    assign {cigar_op, cigar_len, cigar_last} = cigar_valid ? head : '0;

    // ------------------------------------------------------------------
    // Sticky error flags; a new event wins over clear_err
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            overflow  <= (overflow  & ~clear_err) | ovf_evt;
            proto_err <= (proto_err & ~clear_err) | proto_evt;
        end
    end

endmodule
